// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: widths, opcodes and
// the branch-flush controller state encoding.
package ex_mem_stage_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [5:0]  OPCODE_BNE = 6'h22;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FLUSH1 = 2'b01,
    ST_FLUSH2 = 2'b10
  } state_t;

endpackage

// File: rtl/ex_mem_stage_branch_flush_ctrl.sv
// Branch redirect controller: tracks the two-cycle front-end flush that
// follows a taken branch and drives the fetch redirect.
module branch_flush_ctrl
  import ex_mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              take_branch,
  input  logic [DATA_W-1:0] branch_target,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target,
  output logic              flush_front,
  output logic              run
);

  state_t state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              pc_target <= '0;
    else if (take_branch) pc_target <= branch_target;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (take_branch) state_nxt = ST_FLUSH1;
      ST_FLUSH1: state_nxt = ST_FLUSH2;
      ST_FLUSH2: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // pc_src is decoded from FLUSH1, which lasts exactly one cycle.
  always_comb begin
    pc_src      = 1'b0;
    flush_front = 1'b0;
    run         = 1'b0;
    case (state)
      ST_RUN:    run = 1'b1;
      ST_FLUSH1: begin
        pc_src      = 1'b1;
        flush_front = 1'b1;
      end
      ST_FLUSH2: flush_front = 1'b1;
      default:   run = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, branch resolution
// and squashing of branch and illegal memory-control entries.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  zero_flag,
  input  logic                  branch_en,
  input  logic [DATA_W-1:0]     branch_target,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  reg_write_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  pc_src,
  output logic [DATA_W-1:0]     pc_target,
  output logic                  flush_front
);

  logic run, accept, taken, mem_squash;

  // Outside RUN the stage swallows offered instructions, so it reports ready.
  assign in_ready   = run ? (!out_valid || out_ready) : 1'b1;
  assign accept     = in_valid && in_ready && run;
  assign taken      = accept && branch_en && zero_flag;
  assign mem_squash = branch_en || (mem_read && mem_write);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      mem_addr      <= alu_result;
      mem_wdata     <= store_data;
      rd_out        <= rd_addr;
      reg_write_out <= reg_write && !branch_en;
      mem_read_out  <= mem_read  && !mem_squash;
      mem_write_out <= mem_write && !mem_squash;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  branch_flush_ctrl u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .take_branch   (taken),
    .branch_target (branch_target),
    .pc_src        (pc_src),
    .pc_target     (pc_target),
    .flush_front   (flush_front),
    .run           (run)
  );

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 in_valid  in  1  execute stage presents an instruction.
REQ-004 in_ready  out  1  stage can accept this cycle.
REQ-005 alu_result  in  32  ALU output (datA +/- operand B).
REQ-006 zero_flag  in  1  ALU branch condition, already inverted for opcode 6'h22.
REQ-007 branch_en  in  1  instruction is a conditional branch.
REQ-008 branch_target  in  32  computed branch destination PC.
REQ-009 store_data  in  32  register B data for stores.
REQ-010 rd_addr  in  5  destination register; reg_write, mem_read, mem_write  in  1 each  control bits.
REQ-011 out_valid  out  1  registered entry present for memory stage.
REQ-012 out_ready  in  1  memory stage accepts entry.
REQ-013 mem_addr, mem_wdata  out  32 each  registered alu_result / store_data.
REQ-014 rd_out  out  5; reg_write_out, mem_read_out, mem_write_out  out  1 each  registered controls.
REQ-015 pc_src  out  1  one-cycle pulse: redirect fetch to pc_target.
REQ-016 pc_target  out  32  registered branch target; held until next taken branch.
REQ-017 flush_front  out  1  kill younger instructions in IF/ID and ID/EX.

Function
REQ-018 in_ready SHALL equal (!out_valid || out_ready) && state==RUN, or 1 during FLUSH1/FLUSH2 (drain).
REQ-019 Accept = in_valid && in_ready && state==RUN; on accept all data/control outputs SHALL load next edge, out_valid=1.
REQ-020 out_valid SHALL clear on out_ready && out_valid without simultaneous accept; accept+drain same cycle SHALL replace entry, no bubble.
REQ-021 Without accept and with out_ready=0, all outputs SHALL hold (stall).
REQ-022 Branch taken = accept && branch_en && zero_flag; entry SHALL still load with reg_write_out, mem_read_out, mem_write_out forced 0.
REQ-023 Not-taken branch SHALL load as bubble (controls forced 0) and cause no redirect.
REQ-024 Taken: next edge pc_src=1 for exactly one cycle, pc_target=branch_target, state RUN->FLUSH1.
REQ-025 FSM: RUN, FLUSH1, FLUSH2; FLUSH1->FLUSH2->RUN unconditionally, one cycle each, independent of out_ready.
REQ-026 flush_front SHALL be 1 in FLUSH1 and FLUSH2 only; in_valid instructions offered there SHALL be discarded, never loaded.
REQ-027 Memory-side drain (out_ready) SHALL continue normally during FLUSH states.
REQ-028 mem_read and mem_write both 1 on input: entry SHALL load with both forced 0 (illegal, squashed).
REQ-029 Latency: input to outputs 1 cycle; branch resolve to pc_src 1 cycle.

Reset
REQ-030 rst=1 SHALL immediately force state=RUN, out_valid=0, pc_src=0, flush_front=0, all control outputs 0, pc_target=0, mem_addr=0, mem_wdata=0, rd_out=0.
REQ-031 Reset during FLUSH1/FLUSH2 SHALL abort flush; first post-reset cycle in RUN, in_ready=1.
REQ-032 Deassertion SHALL take effect at next rising edge with no spurious pc_src.

Structure
REQ-033 Shared package/include SHALL hold FSM state encodings (2-bit), OPCODE_BNE=6'h22, DATA_W=32, REG_ADDR_W=5.
REQ-034 FSM and pc_src/flush_front generation SHALL live in sub-module branch_flush_ctrl; datapath register stays in ex_mem_stage.

Verification
REQ-035 Streaming: in_valid=1, out_ready=1, alu_result 0x10,0x14,0x18 -> mem_addr 0x10,0x14,0x18 on consecutive cycles, out_valid steady 1.
REQ-036 Stall: out_ready=0 two cycles with entry 0x20 held -> mem_addr stays 0x20, in_ready=0, next input not lost after out_ready=1.
REQ-037 Taken branch: branch_en=1, zero_flag=1, branch_target=0x100 -> pc_src pulse 1 cycle, pc_target=0x100, flush_front 2 cycles, two offered instructions discarded.
REQ-038 Not taken: branch_en=1, zero_flag=0 -> pc_src=0, flush_front=0, bubble with reg_write_out=0.
REQ-039 Reset in FLUSH1 -> out_valid=0, flush_front=0 immediately; after release, instruction alu_result=0x40 accepted next cycle.
REQ-040 Illegal controls mem_read=mem_write=1, alu_result=0x8 -> both outputs 0, mem_addr=0x8.
